ysyx_23060020_lsu_resp: RTL and testbench

//  Data-memory responder for the core's load/store control (memvalid, wen, wmask, load_signed_extends).

---
 rtl/ysyx_23060020_lsu_resp.sv | 222 ++++++++++++++++++++++
 tb/tb_ysyx_23060020_lsu_resp.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060020_lsu_resp.sv
// Load/store responder: accepts one core request, drives a word-addressed data memory
// with byte strobes, and returns a lane-shifted, sign/zero-extended load result.
module ysyx_23060020_lsu_resp #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [3:0]  req_wmask_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_req_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              wen_q, wen_d;
    logic [3:0]        wmask_q, wmask_d;
    logic              sgn_q, sgn_d;
    logic [1:0]        off_q, off_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wen_q, mem_wen_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;

    logic              req_bad_s;
    logic [1:0]        req_off_s;
    logic [3:0]        req_wstrb_s;
    logic [31:0]       req_wdata_s;
    logic [TO_W-1:0]   cnt_inc_s;
    logic              timeout_s;

    // Shift the fetched word down to the addressed lane, then extend to 32 bits by access size.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [3:0]  mask,
        input logic        sgn
    );
        logic [31:0] w;
        w = word >> {off, 3'b000};
        case (mask)
            4'b0001: load_extend = {{24{sgn & w[7]}}, w[7:0]};
            4'b0011: load_extend = {{16{sgn & w[15]}}, w[15:0]};
            default: load_extend = w;
        endcase
    endfunction

    // Classify the incoming request and pre-compute its lane-shifted strobes and write data.
    always_comb begin
        req_off_s   = req_addr_i[1:0];
        req_bad_s   = 1'b1;
        case (req_wmask_i)
            4'b0001: req_bad_s = 1'b0;
            4'b0011: req_bad_s = req_off_s[0];
            4'b1111: req_bad_s = (req_off_s != 2'b00);
            default: req_bad_s = 1'b1;
        endcase
        req_wstrb_s = req_wmask_i << req_off_s;
        req_wdata_s = req_wdata_i << {req_off_s, 3'b000};
    end

    // Timeout fires on the REQ cycle whose increment would reach TIMEOUT.
    always_comb begin
        cnt_inc_s = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        timeout_s = (cnt_inc_s == TO_W'(TIMEOUT));
    end

    // Next-state and next-value logic for the FSM and every registered output.
    always_comb begin
        state_d     = state_q;
        wen_d       = wen_q;
        wmask_d     = wmask_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    wen_d   = req_wen_i;
                    wmask_d = req_wmask_i;
                    sgn_d   = req_signed_i;
                    off_d   = req_off_s;
                    cnt_d   = {TO_W{1'b0}};
                    if (req_bad_s) begin
                        // Rejected requests never touch memory.
                        state_d = S_RESP;
                        rdata_d = 32'h0000_0000;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_wen_d   = req_wen_i;
                        mem_addr_d  = {req_addr_i[31:2], 2'b00};
                        mem_wstrb_d = req_wstrb_s;
                        mem_wdata_d = req_wdata_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_ack_i) begin
                    state_d     = S_RESP;
                    rdata_d     = wen_q ? 32'h0000_0000
                                        : load_extend(mem_rdata_i, off_q, wmask_q, sgn_q);
                    err_d       = 1'b0;
                    mem_req_d   = 1'b0;
                    mem_wen_d   = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    cnt_d       = {TO_W{1'b0}};
                end else if (timeout_s) begin
                    state_d     = S_RESP;
                    rdata_d     = 32'h0000_0000;
                    err_d       = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_wen_d   = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    cnt_d       = {TO_W{1'b0}};
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                mem_req_d   = 1'b0;
                mem_wen_d   = 1'b0;
                mem_wstrb_d = 4'b0000;
                cnt_d       = {TO_W{1'b0}};
            end
        endcase
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            wen_q        <= 1'b0;
            wmask_q      <= 4'b0000;
            sgn_q        <= 1'b0;
            off_q        <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wstrb_q  <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
            rdata_q      <= 32'h0000_0000;
            err_q        <= 1'b0;
            cnt_q        <= {TO_W{1'b0}};
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            wen_q        <= wen_d;
            wmask_q      <= wmask_d;
            sgn_q        <= sgn_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_wen_o    = mem_wen_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wstrb_o  = mem_wstrb_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_ysyx_23060020_lsu_resp.sv
// Directed plus randomized bench for ysyx_23060020_lsu_resp with a behavioural load/store model.
module tb_ysyx_23060020_lsu_resp;

    localparam int unsigned TO = 8;

    logic        clk, rst;
    logic        req_valid, req_ready, req_wen, req_signed;
    logic [3:0]  req_wmask;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_wen, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060020_lsu_resp #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_wen_i    (req_wen),
        .req_wmask_i  (req_wmask),
        .req_signed_i (req_signed),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_req_o    (mem_req),
        .mem_wen_o    (mem_wen),
        .mem_addr_o   (mem_addr),
        .mem_wstrb_o  (mem_wstrb),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {err, rdata} from the access rules, ignoring timeouts.
    function automatic logic [32:0] model(input logic wen, input logic [3:0] mask, input logic sgn,
                                          input logic [31:0] addr, input logic [31:0] rd);
        int off;
        longint w, v;
        off = int'(addr % 32'd4);
        if (!(mask == 4'd1 || mask == 4'd3 || mask == 4'd15)) return {1'b1, 32'd0};
        if (mask == 4'd3 && (off % 2) != 0) return {1'b1, 32'd0};
        if (mask == 4'd15 && off != 0) return {1'b1, 32'd0};
        if (wen) return {1'b0, 32'd0};
        w = longint'(rd) / (longint'(1) << (8 * off));
        if (mask == 4'd1) begin
            v = w % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (mask == 4'd3) begin
            v = w % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return {1'b0, v[31:0]};
    endfunction

    task automatic txn(input string tag, input logic wen, input logic [3:0] mask, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rword,
                       input int ack_dly, input int bp_dly);
        logic [32:0] exp;
        logic        bad;
        int          off;
        logic [31:0] exp_addr, exp_wdata, sh;
        logic [3:0]  exp_strb;
        exp = model(wen, mask, sgn, addr, rword);
        bad = exp[32];
        if (!bad && ack_dly >= int'(TO)) exp = {1'b1, 32'd0};
        off       = int'(addr % 32'd4);
        exp_addr  = addr - (addr % 32'd4);
        sh        = 32'd1 << (8 * off);
        exp_wdata = wdata * sh;
        sh        = 32'(mask) * (32'd1 << off);
        exp_strb  = sh[3:0];

        chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wen = wen; req_wmask = mask; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        tick();
        // Cycle 1: scramble request fields; they must not be latched outside IDLE.
        req_valid = 1'($urandom); req_wen = 1'($urandom); req_wmask = 4'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_signed = 1'($urandom);
        if (bad) begin
            chk({tag, "/err_mem_req"}, 32'(mem_req), 32'd0);
        end else begin
            chk({tag, "/mem_req"}, 32'(mem_req), 32'd1);
            chk({tag, "/mem_wen"}, 32'(mem_wen), 32'(wen));
            chk({tag, "/mem_addr"}, mem_addr, exp_addr);
            chk({tag, "/mem_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
            if (wen) chk({tag, "/mem_wdata"}, mem_wdata, exp_wdata);
            chk({tag, "/early_resp"}, 32'(resp_valid), 32'd0);
            for (int c = 0; c < int'(TO); c++) begin
                if (c == ack_dly) begin
                    mem_ack = 1'b1; mem_rdata = rword;
                    tick();
                    mem_ack = 1'b0; mem_rdata = $urandom;
                    break;
                end
                mem_ack = 1'b0; mem_rdata = $urandom;
                tick();
                if (c < int'(TO) - 1) begin
                    chk({tag, "/held_req"}, 32'(mem_req), 32'd1);
                    chk({tag, "/held_addr"}, mem_addr, exp_addr);
                    chk({tag, "/held_strb"}, 32'(mem_wstrb), 32'(exp_strb));
                    chk({tag, "/wait_resp"}, 32'(resp_valid), 32'd0);
                end
            end
        end
        chk({tag, "/resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "/resp_err"}, 32'(resp_err), 32'(exp[32]));
        chk({tag, "/resp_rdata"}, resp_rdata, exp[31:0]);
        chk({tag, "/drop_req"}, 32'(mem_req), 32'd0);
        chk({tag, "/drop_wen"}, 32'(mem_wen), 32'd0);
        chk({tag, "/drop_strb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, "/busy"}, 32'(req_ready), 32'd0);
        resp_ready = 1'b0;
        for (int b = 0; b < bp_dly; b++) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
            tick();
            chk({tag, "/bp_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, "/bp_rdata"}, resp_rdata, exp[31:0]);
            chk({tag, "/bp_err"}, 32'(resp_err), 32'(exp[32]));
        end
        mem_ack = 1'b0; resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0; req_valid = 1'b0;
        chk({tag, "/resp_fall"}, 32'(resp_valid), 32'd0);
        chk({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "/hold_rdata"}, resp_rdata, exp[31:0]);
        chk({tag, "/hold_err"}, 32'(resp_err), 32'(exp[32]));
    endtask

    initial begin
        logic [3:0]  masks [5];
        logic [3:0]  m;
        logic [31:0] a;
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_wmask = 4'd0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        #1;
        chk("rst/req_ready", 32'(req_ready), 32'd1);
        chk("rst/resp_valid", 32'(resp_valid), 32'd0);
        chk("rst/resp_err", 32'(resp_err), 32'd0);
        chk("rst/resp_rdata", resp_rdata, 32'd0);
        chk("rst/mem_req", 32'(mem_req), 32'd0);
        chk("rst/mem_wen", 32'(mem_wen), 32'd0);
        chk("rst/mem_addr", mem_addr, 32'd0);
        chk("rst/mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst/mem_wdata", mem_wdata, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        txn("lw", 1'b0, 4'b1111, 1'b0, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 0, 0);
        txn("lb", 1'b0, 4'b0001, 1'b1, 32'h8000_0003, 32'd0, 32'h80F1_7F82, 0, 0);
        txn("lbu", 1'b0, 4'b0001, 1'b0, 32'h8000_0000, 32'd0, 32'h80F1_7F82, 0, 1);
        txn("lh", 1'b0, 4'b0011, 1'b1, 32'h8000_0002, 32'd0, 32'h80F1_7F82, 1, 0);
        txn("lhu", 1'b0, 4'b0011, 1'b0, 32'h8000_0002, 32'd0, 32'h80F1_7F82, 0, 0);
        txn("sb", 1'b1, 4'b0001, 1'b0, 32'h8000_0101, 32'h0000_00AB, 32'hFFFF_FFFF, 0, 0);
        txn("sh", 1'b1, 4'b0011, 1'b0, 32'h8000_0102, 32'h0000_1234, 32'hFFFF_FFFF, 2, 0);
        txn("mis_lw", 1'b0, 4'b1111, 1'b0, 32'h8000_0002, 32'd0, 32'h1234_5678, 0, 0);
        txn("mis_lh", 1'b0, 4'b0011, 1'b1, 32'h8000_0001, 32'd0, 32'h1234_5678, 0, 0);
        txn("bad_mask", 1'b1, 4'b0111, 1'b0, 32'h8000_0000, 32'h55, 32'h1234_5678, 0, 0);
        txn("wait5", 1'b0, 4'b1111, 1'b0, 32'h8000_0010, 32'd0, 32'hCAFE_F00D, 5, 3);
        txn("timeout", 1'b0, 4'b1111, 1'b0, 32'h8000_0020, 32'd0, 32'h0BAD_0BAD, int'(TO), 1);

        // Reset in the middle of a REQ phase.
        req_valid = 1'b1; req_wen = 1'b0; req_wmask = 4'b1111; req_addr = 32'h8000_0040;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_rst/pre_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst/mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst/resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst/req_ready", 32'(req_ready), 32'd1);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        chk("stray_ack/mem_req", 32'(mem_req), 32'd0);
        chk("stray_ack/resp_valid", 32'(resp_valid), 32'd0);
        chk("stray_ack/req_ready", 32'(req_ready), 32'd1);
        mem_ack = 1'b0;
        txn("post_rst", 1'b0, 4'b0001, 1'b1, 32'h8000_0042, 32'd0, 32'h00FE_0000, 0, 0);

        masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b1111; masks[3] = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            masks[4] = 4'($urandom);
            m = masks[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (m == 4'b1111) a[1:0] = 2'b00;
                if (m == 4'b0011) a[0] = 1'b0;
            end
            txn("rand", 1'($urandom), m, 1'($urandom), a, $urandom, $urandom,
                $urandom_range(0, 9), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
